// File: rtl/polaris_ifetch_queue_if.sv
// polaris_ifetch_queue_if: I-bus fetch port plus sequencer-side queue handshake.
interface polaris_ifetch_queue_if #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
);
  logic [XLEN-1:0]        iadr_o;
  logic [1:0]             isiz_o;
  logic                   istb_o;
  logic                   iack_i;
  logic [31:0]            idat_i;
  logic                   inst_valid_o;
  logic [31:0]            inst_o;
  logic [XLEN-1:0]        inst_pc_o;
  logic                   inst_ready_i;
  logic                   redirect_i;
  logic [XLEN-1:0]        redirect_pc_i;
  logic [$clog2(DEPTH):0] count_o;
  logic                   discarding_o;
  modport master (
    output iadr_o, isiz_o, istb_o, inst_valid_o, inst_o, inst_pc_o, count_o, discarding_o,
    input  iack_i, idat_i, inst_ready_i, redirect_i, redirect_pc_i
  );
  modport slave (
    input  iadr_o, isiz_o, istb_o, inst_valid_o, inst_o, inst_pc_o, count_o, discarding_o,
    output iack_i, idat_i, inst_ready_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/polaris_ifetch_queue.sv
// polaris_ifetch_queue: autonomous prefetcher filling a DEPTH-entry {pc, instruction} queue.
module polaris_ifetch_queue #(
  parameter int          XLEN         = 64,
  parameter int          DEPTH        = 4,
  parameter logic [63:0] RESET_VECTOR = 64'hFFFF_FFFF_FFFF_FF00
) (
  input logic clk_i,
  input logic reset_i,
  polaris_ifetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;
  state_t          r_state, w_next;
  logic [XLEN-1:0] r_fpc, r_dadr, w_target;
  logic [AW-1:0]   r_rd, r_wr;
  logic [CW-1:0]   r_cnt, w_cnt_pop, w_cnt_next;
  logic [XLEN-1:0] r_pc [DEPTH];
  logic [31:0]     r_inst [DEPTH];
  logic            w_pop, w_push, w_empty;
  assign w_target   = bus.redirect_pc_i & ~XLEN'(3);
  assign w_empty    = r_cnt == '0;
  assign w_pop      = bus.inst_ready_i & ~w_empty & ~bus.redirect_i;
  assign w_push     = (r_state == FETCH) & bus.iack_i & ~bus.redirect_i;
  assign w_cnt_pop  = r_cnt - CW'(w_pop);
  assign w_cnt_next = w_cnt_pop + CW'(w_push);
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) r_state <= IDLE;
    else r_state <= w_next;
  // A redirect with the bus still busy must wait out the old ack in DISCARD.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !bus.redirect_i && w_cnt_pop < CW'(DEPTH) ? FETCH : IDLE;
      FETCH:   w_next = bus.redirect_i ? (bus.iack_i ? IDLE : DISCARD)
                      : !bus.iack_i ? FETCH
                      : w_cnt_next < CW'(DEPTH) ? FETCH : IDLE;
      default: w_next = bus.iack_i ? IDLE : DISCARD;
    endcase
  end
  always_comb begin
    bus.istb_o       = r_state != IDLE;
    bus.iadr_o       = r_state == FETCH ? r_fpc : r_state == DISCARD ? r_dadr : '0;
    bus.isiz_o       = r_state != IDLE ? 2'b10 : 2'b00;
    bus.discarding_o = r_state == DISCARD;
    bus.inst_valid_o = !w_empty;
    bus.inst_o       = w_empty ? '0 : r_inst[r_rd];
    bus.inst_pc_o    = w_empty ? '0 : r_pc[r_rd];
    bus.count_o      = r_cnt;
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      r_fpc  <= RESET_VECTOR[XLEN-1:0];
      r_dadr <= '0;
      r_rd   <= '0;
      r_wr   <= '0;
      r_cnt  <= '0;
    end else begin
      r_cnt <= bus.redirect_i ? '0 : w_cnt_next;
      r_rd  <= bus.redirect_i ? '0 : r_rd + AW'(w_pop);
      r_wr  <= bus.redirect_i ? '0 : r_wr + AW'(w_push);
      r_fpc <= bus.redirect_i ? w_target : w_push ? r_fpc + XLEN'(4) : r_fpc;
      if (bus.redirect_i && r_state == FETCH) r_dadr <= r_fpc;
    end
  always_ff @(posedge clk_i)
    if (w_push) begin
      r_pc[r_wr]   <= r_fpc;
      r_inst[r_wr] <= bus.idat_i;
    end
endmodule
